// File: rtl/fsmc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_pkg
// Brief    : Shared constants and state encoding for the FSMC wait-state slave.
// Revision : 1.0 - initial release
// ============================================================================
package fsmc_pkg;

    localparam int          c_sync_min         = 2;
    localparam logic [15:0] c_err_data_default = 16'hDEAD;

    localparam int c_st_idle_bit     = 0;
    localparam int c_st_write_bit    = 1;
    localparam int c_st_rd_wait_bit  = 2;
    localparam int c_st_rd_drive_bit = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'(1 << c_st_idle_bit),
        ST_WRITE    = 4'(1 << c_st_write_bit),
        ST_RD_WAIT  = 4'(1 << c_st_rd_wait_bit),
        ST_RD_DRIVE = 4'(1 << c_st_rd_drive_bit)
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fsmc_wait_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_wait_slave_if
// Brief    : FSMC pad-side strobes plus backend read/write port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface fsmc_wait_slave_if #(
    parameter int ADRW = 8,
    parameter int DATW = 16
);
    logic                aNE;
    logic                aNOE;
    logic                aNWE;
    logic [DATW/8-1:0]   aNBL;
    logic [ADRW-1:0]     aAn;
    logic [DATW-1:0]     aDn;
    logic                io_output;
    logic [DATW-1:0]     io_data;
    logic                aNWAIT;
    logic                rd_req;
    logic [ADRW-1:0]     rd_adr;
    logic [DATW-1:0]     rd_data;
    logic                rd_valid;
    logic                wr_req;
    logic [ADRW-1:0]     wr_adr;
    logic [DATW-1:0]     wr_data;
    logic [DATW/8-1:0]   wr_be;
    logic [7:0]          err_count;

    modport slave (
        input  aNE, aNOE, aNWE, aNBL, aAn, aDn, rd_data, rd_valid,
        output io_output, io_data, aNWAIT, rd_req, rd_adr,
               wr_req, wr_adr, wr_data, wr_be, err_count
    );

    modport master (
        output aNE, aNOE, aNWE, aNBL, aAn, aDn, rd_data, rd_valid,
        input  io_output, io_data, aNWAIT, rd_req, rd_adr,
               wr_req, wr_adr, wr_data, wr_be, err_count
    );
endinterface
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : W-bit wide, STAGES-deep flop synchroniser with async reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int           W       = 1,
    parameter int           STAGES  = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage_d [STAGES];
    logic [W-1:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign stage_d[i] = d;
        end else begin : g_rest
            assign stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign q = stage_q[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/fsmc_wait_slave.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_wait_slave
// Brief    : FSMC async SRAM-style slave with NWAIT stretching, byte lanes and read timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fsmc_wait_slave
    import fsmc_pkg::*;
#(
    parameter int          ADRW     = 8,
    parameter int          DATW     = 16,
    parameter int          SYNC     = 2,
    parameter int          TIMEOUT  = 64,
    parameter logic [15:0] ERR_DATA = c_err_data_default
) (
    input  logic             clk,
    input  logic             rst,
    fsmc_wait_slave_if.slave bus
);
    localparam int              c_nbl      = DATW / 8;
    localparam logic [DATW-1:0] c_err_word = DATW'(ERR_DATA);

    if (SYNC < c_sync_min || (DATW % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("fsmc_wait_slave: illegal parameter set");
    end

    logic [2:0] w_sync;
    logic       w_sne, w_snoe, w_snwe;

    // Chain resets to "all strobes asserted" so nothing starts until a genuine idle is seen.
    sync_chain #(.W(3), .STAGES(SYNC), .RST_VAL(3'b000)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({bus.aNE, bus.aNOE, bus.aNWE}),
        .q   (w_sync)
    );
    assign {w_sne, w_snoe, w_snwe} = w_sync;

    state_e            state_q,     state_d;
    logic              armed_q,     armed_d;
    logic              rd_req_q,    rd_req_d;
    logic              wr_req_q,    wr_req_d;
    logic              nwait_q,     nwait_d;
    logic [DATW-1:0]   io_data_q,   io_data_d;
    logic [ADRW-1:0]   rd_adr_q,    rd_adr_d;
    logic [ADRW-1:0]   wr_adr_q,    wr_adr_d;
    logic [DATW-1:0]   wr_data_q,   wr_data_d;
    logic [c_nbl-1:0]  wr_be_q,     wr_be_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [7:0]        tmo_cnt_q,   tmo_cnt_d;

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | (w_sne & w_snoe & w_snwe);
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        nwait_d     = nwait_q;
        io_data_d   = io_data_q;
        rd_adr_d    = rd_adr_q;
        wr_adr_d    = wr_adr_q;
        wr_data_d   = wr_data_q;
        wr_be_d     = wr_be_q;
        err_count_d = err_count_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                nwait_d = 1'b1;
                if (armed_q && !w_sne && !w_snwe && w_snoe) begin
                    wr_adr_d  = bus.aAn;
                    wr_data_d = bus.aDn;
                    wr_be_d   = ~bus.aNBL;
                    wr_req_d  = 1'b1;
                    state_d   = ST_WRITE;
                end else if (armed_q && !w_sne && !w_snoe && w_snwe) begin
                    rd_adr_d  = bus.aAn;
                    rd_req_d  = 1'b1;
                    nwait_d   = 1'b0;
                    tmo_cnt_d = 8'(TIMEOUT);
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_WRITE: begin
                if (w_sne || w_snwe) state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                // A host abort takes precedence so the pads are never driven into a dead cycle.
                if (w_sne || w_snoe) begin
                    nwait_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.rd_valid) begin
                    io_data_d = bus.rd_data;
                    nwait_d   = 1'b1;
                    state_d   = ST_RD_DRIVE;
                end else if (tmo_cnt_q == 8'd0) begin
                    io_data_d   = c_err_word;
                    err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
                    nwait_d     = 1'b1;
                    state_d     = ST_RD_DRIVE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 8'd1;
                end
            end
            ST_RD_DRIVE: begin
                nwait_d = 1'b1;
                if (w_sne || w_snoe) state_d = ST_IDLE;
            end
            default: begin
                nwait_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            nwait_q     <= 1'b1;
            io_data_q   <= '0;
            rd_adr_q    <= '0;
            wr_adr_q    <= '0;
            wr_data_q   <= '0;
            wr_be_q     <= '0;
            err_count_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            nwait_q     <= nwait_d;
            io_data_q   <= io_data_d;
            rd_adr_q    <= rd_adr_d;
            wr_adr_q    <= wr_adr_d;
            wr_data_q   <= wr_data_d;
            wr_be_q     <= wr_be_d;
            err_count_q <= err_count_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.io_output = state_q[c_st_rd_drive_bit];
    assign bus.io_data   = io_data_q;
    assign bus.aNWAIT    = nwait_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_adr    = rd_adr_q;
    assign bus.wr_req    = wr_req_q;
    assign bus.wr_adr    = wr_adr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_be     = wr_be_q;
    assign bus.err_count = err_count_q;
endmodule
`default_nettype wire
